// File: rtl/systolic_skew_feeder_if.sv
// Vector handshake and skewed-lane bundle between a producer and the west-edge skew feeder.
interface systolic_skew_feeder_if #(
  parameter int N         = 8,
  parameter int DATA_SIZE = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N*DATA_SIZE-1:0] in_data;
  logic [N*DATA_SIZE-1:0] out_data;
  logic [N-1:0]           out_valid;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// West-edge input stager: accepts N-element vectors and emits them diagonally skewed,
// lane r delayed r cycles, then flushes with bubbles and pulses done.
module systolic_skew_feeder #(
  parameter int N         = 8,
  parameter int DATA_SIZE = 8,
  parameter int LEN_W     = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     start,
  input  logic [LEN_W-1:0]         cfg_len,
  systolic_skew_feeder_if.slave    bus,
  output logic                     busy,
  output logic                     done
);
  localparam int FW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              accept;

  assign bus.in_ready = en && (state_q == S_STREAM);
  assign accept       = bus.in_ready && bus.in_valid;
  assign busy         = (state_q != S_IDLE);
  // done is qualified by en so a frozen DONE state cannot stretch the pulse
  assign done         = en && (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    flush_d = flush_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          count_d = '0;
          state_d = (cfg_len != '0) ? S_STREAM : S_DONE;
        end
      end
      S_STREAM: begin
        if (accept) begin
          count_d = count_q + 1'b1;
          if (count_d == len_q) begin
            state_d = S_FLUSH;
            flush_d = '0;
          end
        end
      end
      S_FLUSH: begin
        // N flush edges after the last accept lets lane N-1 drain before done
        if (flush_q == FW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      flush_q <= '0;
    end else if (en) begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      flush_q <= flush_d;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_lane
    localparam int W  = (r + 1) * DATA_SIZE;
    localparam int VW = r + 1;

    logic [W-1:0]         d_q;
    logic [VW-1:0]        v_q;
    logic [DATA_SIZE-1:0] head;

    assign head = accept ? bus.in_data[r*DATA_SIZE +: DATA_SIZE] : '0;

    // Chain of r+1 stages packed LSB-first; the oldest element sits in the top slice
    always_ff @(posedge clk) begin
      if (!reset) begin
        d_q <= '0;
        v_q <= '0;
      end else if (en) begin
        d_q <= (d_q << DATA_SIZE) | W'(head);
        v_q <= (v_q << 1) | VW'(accept);
      end
    end

    assign bus.out_data[r*DATA_SIZE +: DATA_SIZE] = d_q[r*DATA_SIZE +: DATA_SIZE];
    assign bus.out_valid[r]                       = v_q[r];
  end
endmodule
